sysref_capture_ctrl: RTL

Parametrised PL SYSREF capture and distribution block. Takes the already-buffered PL SYSREF level in the pl_clk domain and resynchronises it. Measures the period between rising edges and declares lock after a programmable number of matching periods. Forwards qualified SYSREF pulses to NUM_CH per-channel outputs in continuous or armed one-shot mode, and flags period errors for the RF-ADC/RF-DAC alignment logic.

---
 rtl/sysref_capture_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sysref_capture_ctrl.sv
// sysref_capture_ctrl: resynchronises the PL SYSREF level, measures the
// distance between rising edges, locks after LOCK_COUNT consecutive
// in-tolerance periods and forwards qualified edges to NUM_CH gated outputs
// (continuous or armed one-shot). Define SYSREF_EDGE_CNT_EN to add the
// saturating edge_cnt output that counts every detected rise.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_UNLOCKED  | waiting for a reference rise, nothing forwarded
// ST_ACQUIRE   | counting consecutive in-tolerance periods towards lock
// ST_LOCKED    | matching rises are qualified and may be forwarded
module sysref_capture_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                pl_clk,
    input  logic                pl_rst_n,
    input  logic                pl_sysref,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                continuous,
    input  logic                arm,
    input  logic [PERIOD_W-1:0] expected_period,
    input  logic [3:0]          tolerance,
    input  logic                clr_err,
    output logic [NUM_CH-1:0]   sysref_adc,
    output logic                locked,
    output logic                armed,
    output logic                period_err,
    output logic [PERIOD_W-1:0] measured_period
`ifdef SYSREF_EDGE_CNT_EN
    ,
    output logic [15:0]         edge_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] CNT_PRE = {{(PERIOD_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]          LOCK_LAST = 4'(LOCK_COUNT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             match_cnt;
    logic [3:0]             match_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_last;
    logic                   s_prev;
    logic                   rise;
    logic [PERIOD_W-1:0]    period_cnt;
    logic                   timeout;
    logic [PERIOD_W:0]      diff;
    logic [PERIOD_W:0]      abs_diff;
    logic                   match_ok;
    logic                   qualified;
    logic                   lock_loss;
    logic                   fwd;

    assign s_last  = sync_q[SYNC_STAGES-1];
    assign rise    = s_last & ~s_prev;
    // The counter reaches all-ones only through this transition, so the
    // timeout event fires once per silent gap.
    assign timeout = ~rise & (period_cnt == CNT_PRE);

    assign diff     = {1'b0, period_cnt} - {1'b0, expected_period};
    assign abs_diff = diff[PERIOD_W] ? (~diff + 1'b1) : diff;
    assign match_ok = (abs_diff <= (PERIOD_W+1)'(tolerance));

    assign fwd    = qualified & (continuous | armed);
    assign locked = (state == ST_LOCKED);

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pl_sysref};
            s_prev <= s_last;
        end
    end

    // Edge-to-edge period counter; restarts at 1 so the capture equals the
    // number of cycles between rises, and holds at all-ones on timeout.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            period_cnt      <= '0;
            measured_period <= '0;
        end else begin
            if (rise) begin
                period_cnt      <= PERIOD_W'(1);
                measured_period <= period_cnt;
            end else begin
                if (period_cnt != CNT_MAX) begin
                    period_cnt <= period_cnt + 1'b1;
                end
                if (timeout) begin
                    measured_period <= CNT_MAX;
                end
            end
        end
    end

    // FSM state and match counter registers.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            state     <= ST_UNLOCKED;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_cnt_nxt;
        end
    end

    // Next-state logic: lock acquisition, loss of lock and edge qualification.
    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        qualified     = 1'b0;
        lock_loss     = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (rise) begin
                    state_nxt     = ST_ACQUIRE;
                    match_cnt_nxt = '0;
                end
            end
            ST_ACQUIRE: begin
                if (timeout) begin
                    match_cnt_nxt = '0;
                end else if (rise) begin
                    if (match_ok) begin
                        if (match_cnt == LOCK_LAST) begin
                            state_nxt     = ST_LOCKED;
                            match_cnt_nxt = '0;
                        end else begin
                            match_cnt_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout || (rise && !match_ok)) begin
                    state_nxt = ST_UNLOCKED;
                    lock_loss = 1'b1;
                end else if (rise) begin
                    qualified = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_UNLOCKED;
                match_cnt_nxt = '0;
            end
        endcase
    end

    // One-shot arm flag: consumed by a forwarded edge, set by arm only when
    // clear, so an arm landing on an unarmed qualified edge arms the next one.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            armed <= 1'b0;
        end else if (armed) begin
            if (fwd && !continuous) begin
                armed <= 1'b0;
            end
        end else if (arm) begin
            armed <= 1'b1;
        end
    end

    // Per-channel gated output: set by a forwarded edge, held by the
    // synchronised level, dropped as soon as the enable goes away.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            sysref_adc <= '0;
        end else begin
            sysref_adc <= ch_en & ({NUM_CH{fwd}} | (sysref_adc & {NUM_CH{s_last}}));
        end
    end

    // Sticky period error; a new error in the clear cycle wins.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            period_err <= 1'b0;
        end else begin
            period_err <= lock_loss | (period_err & ~clr_err);
        end
    end

`ifdef SYSREF_EDGE_CNT_EN
    // Saturating count of every detected rise; a rise in the clear cycle
    // restarts the count at 1.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            edge_cnt <= '0;
        end else if (rise) begin
            if (clr_err) begin
                edge_cnt <= 16'd1;
            end else if (edge_cnt != 16'hFFFF) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end else if (clr_err) begin
            edge_cnt <= '0;
        end
    end
`endif

endmodule
